// File: rtl/craft_enc_if.sv
// Request and result handshake bundle for the CRAFT encryption controller.
// master drives requests and consumes results; slave is the controller.
interface craft_enc_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_plaintext;
    logic [63:0]  in_tweak;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_ciphertext;

    modport master (
        output in_valid, in_plaintext, in_tweak, in_key, out_ready,
        input  in_ready, out_valid, out_ciphertext
    );

    modport slave (
        input  in_valid, in_plaintext, in_tweak, in_key, out_ready,
        output in_ready, out_valid, out_ciphertext
    );
endinterface

// File: rtl/craft_enc_ctrl.sv
// Sequencer and ciphertext FIFO around the iterative CRAFT core.
// Define CRAFT_CTRL_TIMEOUT_EN to enable the RUN-state watchdog.
module craft_enc_ctrl #(
    parameter int FIFO_DEPTH     = 2,
    parameter int DONE_MASK      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    craft_enc_if.slave                  bus,
    output logic                        core_rst_n,
    output logic [63:0]                 core_plaintext,
    output logic [63:0]                 core_tweak,
    output logic [127:0]                core_key,
    input  logic                        core_done,
    input  logic [63:0]                 core_ciphertext,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_timeout
);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int RMAX = (TIMEOUT_CYCLES > DONE_MASK) ? TIMEOUT_CYCLES : DONE_MASK;
    localparam int RW   = $clog2(RMAX + 2);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   run_cnt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [63:0]     mem [FIFO_DEPTH];
    logic            in_ready, out_valid;
    logic            accept, push, pop, done_q, timeout;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready           = (state == IDLE) && !rst && (fifo_count < CW'(FIFO_DEPTH));
    assign out_valid          = (fifo_count != '0);
    assign accept             = bus.in_valid && in_ready;
    assign pop                = out_valid && bus.out_ready;
    assign done_q             = core_done && (run_cnt >= RW'(DONE_MASK));
    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.out_ciphertext = out_valid ? mem[rd_ptr] : '0;
    assign busy               = (state != IDLE);
    assign core_rst_n         = (state == RUN) && !rst;

    always_comb begin
        state_n = state;
        push    = 1'b0;
        timeout = 1'b0;
        unique case (state)
            IDLE: if (accept) state_n = LOAD;
            LOAD: state_n = RUN;
            RUN: begin
                if (done_q) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
`ifdef CRAFT_CTRL_TIMEOUT_EN
                else if (run_cnt >= RW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            run_cnt        <= '0;
            core_plaintext <= '0;
            core_tweak     <= '0;
            core_key       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                core_plaintext <= bus.in_plaintext;
                core_tweak     <= bus.in_tweak;
                core_key       <= bus.in_key;
            end
            // run_cnt saturates so a long RUN never re-enters the mask window
            if (state == LOAD)
                run_cnt <= '0;
            else if (state == RUN && run_cnt != RW'(RMAX))
                run_cnt <= run_cnt + RW'(1);
            if (push) begin
                mem[wr_ptr] <= core_ciphertext;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (!push && pop)
                fifo_count <= fifo_count - CW'(1);
        end
    end

`ifdef CRAFT_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_timeout <= 1'b0;
        else if (timeout)
            err_timeout <= 1'b1;
    end
`else
    assign err_timeout = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout;
`endif
endmodule
